// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: load/start/done handshake between the phase sequencer and its countdown timer
interface traffic_phase_ctrl_if #(parameter int WIDTH = 32);
    logic             tmr_start;
    logic [WIDTH-1:0] tmr_load;
    logic             tmr_done;
    modport master (output tmr_start, tmr_load, input tmr_done);
    modport slave  (input tmr_start, tmr_load, output tmr_done);
endinterface

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: intersection phase sequencer driving NS/EW lights, pedestrian WALK and emergency all-red
module traffic_phase_ctrl #(
    parameter int WIDTH    = 32,
    parameter int T_GREEN  = 50,
    parameter int T_YELLOW = 10,
    parameter int T_ALLRED = 3,
    parameter int T_WALK   = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ped_req,
    input  logic                 emerg,
    traffic_phase_ctrl_if.master tmr,
    output logic [2:0]           ns_light,
    output logic [2:0]           ew_light,
    output logic                 ped_walk,
    output logic                 ped_ack
);
    typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALLRED, WALK, EHOLD} state_t;
    state_t           state, state_n;
    logic             dir, dir_n, pend, pend_n, start_n, ack_n, done;
    logic [WIDTH-1:0] load_n;
    logic [2:0]       go, ns_n, ew_n;
    // a done arriving alongside a fresh load belongs to the aborted countdown
    assign done = tmr.tmr_done && !tmr.tmr_start;
    always_comb begin
        state_n = state;
        dir_n   = dir;
        unique case (state)
            IDLE:    state_n = emerg ? EHOLD : GREEN;
            GREEN:   state_n = (emerg || done) ? YELLOW : GREEN;
            YELLOW:  begin
                state_n = done ? (emerg ? EHOLD : ALLRED) : YELLOW;
                dir_n   = (done && !emerg) ? !dir : dir;
            end
            ALLRED:  state_n = emerg ? EHOLD : done ? (pend ? WALK : GREEN) : ALLRED;
            WALK:    state_n = emerg ? EHOLD : done ? GREEN : WALK;
            EHOLD:   state_n = emerg ? EHOLD : ALLRED;
            default: state_n = IDLE;
        endcase
        // every state change except into EHOLD is a timed phase entry
        start_n = (state_n != state) && (state_n != EHOLD);
        ack_n   = start_n && (state_n == WALK);
        pend_n  = ack_n ? 1'b0 : (pend | ped_req);
        load_n  = start_n ? WIDTH'(state_n == GREEN  ? T_GREEN  :
                                   state_n == YELLOW ? T_YELLOW :
                                   state_n == ALLRED ? T_ALLRED : T_WALK) : tmr.tmr_load;
        go      = state_n == GREEN ? 3'b001 : state_n == YELLOW ? 3'b010 : 3'b100;
        ns_n    = dir_n ? 3'b100 : go;
        ew_n    = dir_n ? go : 3'b100;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            dir           <= 1'b0;
            pend          <= 1'b0;
            ns_light      <= 3'b100;
            ew_light      <= 3'b100;
            ped_walk      <= 1'b0;
            ped_ack       <= 1'b0;
            tmr.tmr_start <= 1'b0;
            tmr.tmr_load  <= '0;
        end else begin
            state         <= state_n;
            dir           <= dir_n;
            pend          <= pend_n;
            ns_light      <= ns_n;
            ew_light      <= ew_n;
            ped_walk      <= state_n == WALK;
            ped_ack       <= ack_n;
            tmr.tmr_start <= start_n;
            tmr.tmr_load  <= load_n;
        end
    end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: randomized scoreboard bench with a behavioural timer and a phase/age reference model
module tb_traffic_phase_ctrl;
    localparam int W = 32, TG = 5, TY = 2, TA = 1, TW = 3;
    logic clk = 1'b0, rst_n = 1'b0, ped_req = 1'b0, emerg = 1'b0, inj = 1'b0;
    logic [2:0] ns_light, ew_light;
    logic ped_walk, ped_ack;
    int tests = 0, fails = 0;

    traffic_phase_ctrl_if #(.WIDTH(W)) tmr();
    traffic_phase_ctrl #(.WIDTH(W), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW)) dut (
        .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .emerg(emerg), .tmr(tmr),
        .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk), .ped_ack(ped_ack));

    always #5 clk = ~clk;

    // behavioural timer: done pulses L+1 cycles after start is sampled; a new start reloads
    logic [W-1:0] cnt;
    logic tdone;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin cnt <= '0; tdone <= 1'b0; end
        else if (tmr.tmr_start) begin cnt <= tmr.tmr_load + 1; tdone <= 1'b0; end
        else begin tdone <= (cnt == 1); cnt <= (cnt == 0) ? '0 : cnt - 1; end
    assign tmr.tmr_done = tdone | inj;

    // reference model: each timed phase lasts T+3 cycles from its entry; no timer is consulted
    typedef enum {P_IDLE, P_GREEN, P_YELLOW, P_ALLRED, P_WALK, P_EHOLD} phase_t;
    phase_t ph = P_IDLE;
    int age = 0;
    bit mdir = 0, mpend = 0, m_start = 0, m_ack = 0;
    int unsigned q_load[$];

    function automatic int dur(phase_t p);
        return p == P_GREEN ? TG : p == P_YELLOW ? TY : p == P_ALLRED ? TA : p == P_WALK ? TW : 0;
    endfunction

    task automatic enter(phase_t p);
        ph = p;
        age = 0;
        if (p != P_EHOLD) begin m_start = 1; q_load.push_back(dur(p)); end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ph = P_IDLE; age = 0; mdir = 0; mpend = 0; m_start = 0; m_ack = 0; q_load.delete();
        end else begin
            bit expired, req;
            expired = (age == dur(ph) + 2);
            req = ped_req;
            m_start = 0; m_ack = 0; age++;
            case (ph)
                P_IDLE:   enter(emerg ? P_EHOLD : P_GREEN);
                P_GREEN:  if (emerg || expired) enter(P_YELLOW);
                P_YELLOW: if (expired) begin
                    if (emerg) enter(P_EHOLD);
                    else begin mdir = !mdir; enter(P_ALLRED); end
                end
                P_ALLRED: if (emerg) enter(P_EHOLD);
                          else if (expired) begin
                              if (mpend) begin mpend = 0; req = 0; m_ack = 1; enter(P_WALK); end
                              else enter(P_GREEN);
                          end
                P_WALK:   if (emerg) enter(P_EHOLD); else if (expired) enter(P_GREEN);
                P_EHOLD:  if (!emerg) enter(P_ALLRED);
                default:  enter(P_IDLE);
            endcase
            mpend = mpend | req;
        end
    end

    function automatic logic [2:0] lamp(bit side);
        if (side != mdir) return 3'b100;
        return ph == P_GREEN ? 3'b001 : ph == P_YELLOW ? 3'b010 : 3'b100;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: per-cycle light/strobe checks, scoreboard pop on every tmr_start
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_ns", ns_light, 3'b100);
            chk("rst_ew", ew_light, 3'b100);
            chk("rst_start", tmr.tmr_start, 0);
            chk("rst_load", tmr.tmr_load, 0);
            chk("rst_walk", ped_walk, 0);
            chk("rst_ack", ped_ack, 0);
        end else begin
            chk("ns_light", ns_light, lamp(0));
            chk("ew_light", ew_light, lamp(1));
            chk("ped_walk", ped_walk, ph == P_WALK);
            chk("ped_ack", ped_ack, m_ack);
            chk("tmr_start", tmr.tmr_start, m_start);
            if (tmr.tmr_start) begin
                if (q_load.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL tmr_load: got strobe with load %0d, expected no strobe", tmr.tmr_load);
                end else chk("tmr_load", tmr.tmr_load, q_load.pop_front());
            end else if (m_start && q_load.size() != 0) void'(q_load.pop_front());
            chk("ns_onehot", $countones(ns_light), 1);
            chk("ew_onehot", $countones(ew_light), 1);
            chk("no_conflict", (ns_light != 3'b100) && (ew_light != 3'b100), 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int what, input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = what == 0 ? ns_light == 3'b001 : what == 1 ? ped_walk :
                  what == 2 ? tmr.tmr_start : ew_light == 3'b010;
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL wait_%0d: got timeout after %0d cycles, expected event", what, budget); end
    endtask

    initial begin
        int ns_g, ew_g, ns_y, walks, acks;
        step(3);
        rst_n = 1'b1;
        ns_g = 0; ew_g = 0; ns_y = 0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            ns_g += int'(ns_light == 3'b001);
            ew_g += int'(ew_light == 3'b001);
            ns_y += int'(ns_light == 3'b010);
        end
        chk("ns_green_len", ns_g, TG + 3);
        chk("ew_green_len", ew_g, TG + 3);
        chk("ns_yellow_len", ns_y, TY + 3);
        step(6);

        wait_for(0, 60);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        walks = 0; acks = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            walks += int'(ped_walk);
            acks  += int'(ped_ack);
        end
        chk("walk_len", walks, TW + 3);
        chk("ack_count", acks, 1);

        wait_for(0, 60);
        step(2);
        emerg = 1'b1;
        step(14);
        emerg = 1'b0;
        step(30);

        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        wait_for(1, 80);
        emerg = 1'b1;
        step(15);
        emerg = 1'b0;
        step(30);

        for (int k = 0; k < 4; k++) begin
            wait_for(2, 40);
            inj = 1'b1;
            @(posedge clk);
            #1 inj = 1'b0;
            step(3);
        end

        for (int i = 0; i < 1500; i++) begin
            ped_req = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 39) == 0) emerg = !emerg;
            step(1);
        end
        ped_req = 1'b0;
        emerg = 1'b0;
        step(30);

        wait_for(3, 80);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ns", ns_light, 3'b100);
        chk("async_ew", ew_light, 3'b100);
        chk("async_start", tmr.tmr_start, 0);
        chk("async_ack", ped_ack, 0);
        chk("async_walk", ped_walk, 0);
        step(3);
        rst_n = 1'b1;
        wait_for(0, 5);
        chk("first_green_ew_red", ew_light, 3'b100);
        step(40);
        @(negedge clk);
        #1;
        chk("queue_drained", q_load.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
